// File: rtl/com_frame_scheduler.sv
// Frame-level scheduler for the center_of_mass datapath: frame alignment, decimation, tabulate/result handshake.
// Optional build macro COM_SMOOTH_EN: accepted results are averaged into x_out/y_out instead of loaded directly.
module com_frame_scheduler #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int DS_SHIFT   = 2,
    parameter int MIN_PIXELS = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  pix_valid_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  mask_in,
    input  logic [10:0]           com_x_in,
    input  logic [9:0]            com_y_in,
    input  logic                  com_valid_in,
    output logic                  ds_valid_out,
    output logic [10-DS_SHIFT:0]  ds_x_out,
    output logic [9-DS_SHIFT:0]   ds_y_out,
    output logic                  tabulate_out,
    output logic [10:0]           x_out,
    output logic [9:0]            y_out,
    output logic                  result_valid_out,
    output logic                  locked_out,
    output logic [7:0]            frame_count_out,
    output logic                  timeout_err_out
);

    // state  | meaning
    // IDLE   | disabled, outputs quiet
    // SYNC   | waiting for pixel (0,0)
    // ACCUM  | decimating and counting masked pixels of the frame
    // TAB    | frame complete, tabulate pulse is being registered
    // WAIT   | waiting for the COM strobe or the timeout
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ACCUM, S_TAB, S_WAIT} state_t;

    localparam int TW = $clog2(TIMEOUT);

    state_t         state, state_nxt;
    logic [19:0]    mask_cnt, mask_cnt_nxt, mask_inc;
    logic [TW-1:0]  tmo_cnt, tmo_cnt_nxt;

    logic                 ds_valid_nxt, tab_nxt, rv_nxt, locked_nxt, terr_nxt;
    logic [10-DS_SHIFT:0] ds_x_nxt;
    logic [9-DS_SHIFT:0]  ds_y_nxt;
    logic [10:0]          x_nxt, x_load;
    logic [9:0]           y_nxt, y_load;
    logic [7:0]           fc_nxt;
    logic                 start, last, on_grid, hit;

    assign start   = pix_valid_in && hcount_in == 11'd0 && vcount_in == 10'd0;
    assign last    = pix_valid_in && hcount_in == 11'(H_ACTIVE - 1) && vcount_in == 10'(V_ACTIVE - 1);
    assign on_grid = hcount_in[DS_SHIFT-1:0] == '0 && vcount_in[DS_SHIFT-1:0] == '0;
    assign hit     = pix_valid_in && mask_in && on_grid;
    assign mask_inc = (mask_cnt == '1) ? mask_cnt : mask_cnt + 20'd1;

`ifdef COM_SMOOTH_EN
    // One extra bit keeps the difference signed; the halved step is added back and truncated.
    logic signed [11:0] dx;
    logic signed [10:0] dy;
    assign dx     = $signed({1'b0, com_x_in}) - $signed({1'b0, x_out});
    assign dy     = $signed({1'b0, com_y_in}) - $signed({1'b0, y_out});
    assign x_load = locked_out ? 11'($signed({1'b0, x_out}) + (dx >>> 1)) : com_x_in;
    assign y_load = locked_out ? 10'($signed({1'b0, y_out}) + (dy >>> 1)) : com_y_in;
`else
    assign x_load = com_x_in;
    assign y_load = com_y_in;
`endif

    always_comb begin
        state_nxt    = state;
        mask_cnt_nxt = mask_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        ds_valid_nxt = 1'b0;
        ds_x_nxt     = ds_x_out;
        ds_y_nxt     = ds_y_out;
        tab_nxt      = 1'b0;
        rv_nxt       = 1'b0;
        x_nxt        = x_out;
        y_nxt        = y_out;
        locked_nxt   = locked_out;
        fc_nxt       = frame_count_out;
        terr_nxt     = timeout_err_out;

        if (!enable_in) begin
            state_nxt    = S_IDLE;
            mask_cnt_nxt = '0;
            terr_nxt     = 1'b0;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_SYNC;
                S_SYNC, S_ACCUM: begin
                    if (state == S_ACCUM || start) begin
                        state_nxt = S_ACCUM;
                        if (hit) begin
                            ds_valid_nxt = 1'b1;
                            ds_x_nxt     = hcount_in[10:DS_SHIFT];
                            ds_y_nxt     = vcount_in[9:DS_SHIFT];
                        end
                        // A start pixel (first or mid-frame restart) begins a fresh count.
                        if (start)
                            mask_cnt_nxt = hit ? 20'd1 : 20'd0;
                        else if (hit)
                            mask_cnt_nxt = mask_inc;
                        if (last)
                            state_nxt = S_TAB;
                    end
                end
                S_TAB: begin
                    tab_nxt     = 1'b1;
                    fc_nxt      = frame_count_out + 8'd1;
                    tmo_cnt_nxt = '0;
                    state_nxt   = S_WAIT;
                end
                S_WAIT: begin
                    if (com_valid_in) begin
                        if (mask_cnt >= 20'(MIN_PIXELS)) begin
                            x_nxt      = x_load;
                            y_nxt      = y_load;
                            rv_nxt     = 1'b1;
                            locked_nxt = 1'b1;
                        end else begin
                            locked_nxt = 1'b0;
                        end
                        mask_cnt_nxt = '0;
                        state_nxt    = S_SYNC;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        terr_nxt     = 1'b1;
                        locked_nxt   = 1'b0;
                        mask_cnt_nxt = '0;
                        state_nxt    = S_SYNC;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= S_IDLE;
            mask_cnt         <= '0;
            tmo_cnt          <= '0;
            ds_valid_out     <= 1'b0;
            ds_x_out         <= '0;
            ds_y_out         <= '0;
            tabulate_out     <= 1'b0;
            x_out            <= '0;
            y_out            <= '0;
            result_valid_out <= 1'b0;
            locked_out       <= 1'b0;
            frame_count_out  <= '0;
            timeout_err_out  <= 1'b0;
        end else begin
            state            <= state_nxt;
            mask_cnt         <= mask_cnt_nxt;
            tmo_cnt          <= tmo_cnt_nxt;
            ds_valid_out     <= ds_valid_nxt;
            ds_x_out         <= ds_x_nxt;
            ds_y_out         <= ds_y_nxt;
            tabulate_out     <= tab_nxt;
            x_out            <= x_nxt;
            y_out            <= y_nxt;
            result_valid_out <= rv_nxt;
            locked_out       <= locked_nxt;
            frame_count_out  <= fc_nxt;
            timeout_err_out  <= terr_nxt;
        end
    end

endmodule
